// File: rtl/spi_vector_loader_pkg.sv
// Shared constants and types for the SPI view-vector loader.
// Default vectors place the player in the start cell, facing -Y.
package spi_vector_loader_pkg;

  localparam int VEC_W_DEF   = 16;
  localparam int NUM_VEC_DEF = 6;

  localparam logic signed [15:0] DEF_PX = 16'sh0580;
  localparam logic signed [15:0] DEF_PY = 16'sh0D80;
  localparam logic signed [15:0] DEF_FX = 16'sh0000;
  localparam logic signed [15:0] DEF_FY = 16'shFF00;
  localparam logic signed [15:0] DEF_VX = 16'sh0080;
  localparam logic signed [15:0] DEF_VY = 16'sh0000;

  typedef enum logic {IDLE, RECV} state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Brings asynchronous SPI pins into the clk domain and flags sclk/ss_n edges.
// mosi sees the same delay as sclk so it is stable when sclk_rise fires.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic ss_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic ss_fall,
  output logic ss_rise,
  output logic mosi_sync,
  output logic ss_n_sync
);

  logic [SYNC_STAGES-1:0] sclk_sr, ss_sr, mosi_sr;
  logic                   sclk_hist, ss_hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sr   <= '0;
      ss_sr     <= '1;
      mosi_sr   <= '0;
      sclk_hist <= 1'b0;
      ss_hist   <= 1'b1;
    end else begin
      sclk_sr[0] <= sclk;
      ss_sr[0]   <= ss_n;
      mosi_sr[0] <= mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sr[i] <= sclk_sr[i-1];
        ss_sr[i]   <= ss_sr[i-1];
        mosi_sr[i] <= mosi_sr[i-1];
      end
      sclk_hist <= sclk_sr[SYNC_STAGES-1];
      ss_hist   <= ss_sr[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_sr[SYNC_STAGES-1] & ~sclk_hist;
  assign ss_rise   = ss_sr[SYNC_STAGES-1] & ~ss_hist;
  assign ss_fall   = ~ss_sr[SYNC_STAGES-1] & ss_hist;
  assign mosi_sync = mosi_sr[SYNC_STAGES-1];
  assign ss_n_sync = ss_sr[SYNC_STAGES-1];

endmodule

// File: rtl/spi_vector_loader.sv
// Receives a full frame of view vectors over SPI, holds it as pending,
// and swaps it onto the outputs only when the frame-boundary commit arrives.
module spi_vector_loader
  import spi_vector_loader_pkg::*;
#(
  parameter int VEC_W       = VEC_W_DEF,
  parameter int NUM_VEC     = NUM_VEC_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_sclk,
  input  logic                    i_mosi,
  input  logic                    i_ss_n,
  input  logic                    i_commit,
  output logic signed [VEC_W-1:0] o_px,
  output logic signed [VEC_W-1:0] o_py,
  output logic signed [VEC_W-1:0] o_fx,
  output logic signed [VEC_W-1:0] o_fy,
  output logic signed [VEC_W-1:0] o_vx,
  output logic signed [VEC_W-1:0] o_vy,
  output logic                    o_pending,
  output logic                    o_busy
);

  localparam int TOTAL = VEC_W * NUM_VEC;
  localparam int CW    = $clog2(TOTAL) + 1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic signed [VEC_W-1:0] vec_slice(input logic [TOTAL-1:0] b,
                                                        input int idx);
    return b[TOTAL-1-idx*VEC_W -: VEC_W];
  endfunction

  logic sclk_rise, ss_fall, ss_rise, mosi_sync, ss_n_sync;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .sclk      (i_sclk),
    .ss_n      (i_ss_n),
    .mosi      (i_mosi),
    .sclk_rise (sclk_rise),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise),
    .mosi_sync (mosi_sync),
    .ss_n_sync (ss_n_sync)
  );

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [TOTAL-1:0] shift_p0;
  logic [TOTAL-1:0] pend_p1;
  logic             frame_ok;
  logic             do_commit;

  assign frame_ok  = (state == RECV) && ss_rise && (cnt == CW'(TOTAL));
  assign do_commit = i_commit && o_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shift_p0  <= '0;
      pend_p1   <= '0;
      o_pending <= 1'b0;
      o_busy    <= 1'b0;
      o_px      <= VEC_W'(DEF_PX);
      o_py      <= VEC_W'(DEF_PY);
      o_fx      <= VEC_W'(DEF_FX);
      o_fy      <= VEC_W'(DEF_FY);
      o_vx      <= VEC_W'(DEF_VX);
      o_vy      <= VEC_W'(DEF_VY);
    end else begin
      o_busy <= ~ss_n_sync;

      // Stage 0: serial capture
      case (state)
        IDLE: if (ss_fall) begin
          state <= RECV;
          cnt   <= '0;
        end
        RECV: if (ss_rise) begin
          state <= IDLE;
        end else if (sclk_rise) begin
          shift_p0 <= {shift_p0[TOTAL-2:0], mosi_sync};
          cnt      <= sat_inc(cnt);
        end
        default: state <= IDLE;
      endcase

      // Stage 1: pending buffer; a new frame wins over both overrun and commit
      if (frame_ok) begin
        pend_p1   <= shift_p0;
        o_pending <= 1'b1;
      end else if (do_commit) begin
        o_pending <= 1'b0;
      end

      // Stage 2: atomic output swap from the pre-edge pending contents
      if (do_commit) begin
        o_px <= vec_slice(pend_p1, 0);
        o_py <= vec_slice(pend_p1, 1);
        o_fx <= vec_slice(pend_p1, 2);
        o_fy <= vec_slice(pend_p1, 3);
        o_vx <= vec_slice(pend_p1, 4);
        o_vy <= vec_slice(pend_p1, 5);
      end
    end
  end

endmodule
